// File: rtl/eth_cmd_decoder.sv
// rtl/eth_cmd_decoder.sv - UDP payload to one-byte LED/7-seg command decoder
// Optional idle auto-clear enabled by defining CMD_TIMEOUT_EN.
module eth_cmd_decoder #(
  parameter logic [7:0] SYNC_BYTE = 8'h55
`ifdef CMD_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 300_000_000
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rec_en,
  input  logic [7:0] rec_data,
  input  logic       rec_pkt_done,
  output logic [7:0] eth_data,
  output logic       flag,
  output logic       cmd_valid,
  output logic [7:0] err_cnt
);

  typedef enum logic [2:0] {S_SYNC, S_CMD, S_INV, S_OK, S_DROP} state_t;

  state_t     state, state_byte, state_next;
  logic [7:0] cmd_tmp, cmd_tmp_next;
  logic       commit, reject, timeout_hit;

  function automatic logic cmd_legal(input logic [7:0] c);
    return (c == 8'h00) || (c == 8'hAA) || (c == 8'hBB) || (c == 8'hCC);
  endfunction

  // state_byte is the state after this cycle's byte; done is judged on it so
  // a final ~CMD byte arriving together with rec_pkt_done still commits.
  always_comb begin
    state_byte   = state;
    cmd_tmp_next = cmd_tmp;
    if (rec_en) begin
      case (state)
        S_SYNC:  state_byte = (rec_data == SYNC_BYTE) ? S_CMD : S_DROP;
        S_CMD: begin
          cmd_tmp_next = rec_data;
          state_byte   = S_INV;
        end
        S_INV:   state_byte = ((rec_data == ~cmd_tmp) && cmd_legal(cmd_tmp)) ? S_OK : S_DROP;
        default: state_byte = state;
      endcase
    end
    commit     = rec_pkt_done && (state_byte == S_OK);
    reject     = rec_pkt_done && (state_byte != S_OK);
    state_next = rec_pkt_done ? S_SYNC : state_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_SYNC;
      cmd_tmp <= 8'h00;
    end else begin
      state   <= state_next;
      cmd_tmp <= cmd_tmp_next;
    end
  end

`ifdef CMD_TIMEOUT_EN
  localparam logic [31:0] IDLE_LAST = 32'(TIMEOUT_CYC - 1);

  logic [31:0] idle_cnt;

  assign timeout_hit = !commit && cmd_valid && (eth_data != 8'h00) && (idle_cnt == IDLE_LAST);

  // Saturates at IDLE_LAST so a stopped or never-valid output does not wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= 32'd0;
    end else if (commit || timeout_hit) begin
      idle_cnt <= 32'd0;
    end else if (idle_cnt != IDLE_LAST) begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eth_data  <= 8'h00;
      flag      <= 1'b0;
      cmd_valid <= 1'b0;
      err_cnt   <= 8'h00;
    end else begin
      flag <= commit || timeout_hit;
      if (commit) begin
        eth_data  <= cmd_tmp;
        cmd_valid <= 1'b1;
      end else if (timeout_hit) begin
        eth_data <= 8'h00;
      end
      if (reject && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_eth_cmd_decoder.sv
// tb/tb_eth_cmd_decoder.sv - directed scoreboard bench for eth_cmd_decoder
// Define CMD_TIMEOUT_EN to also exercise the idle auto-clear with TIMEOUT_CYC=100.
module tb_eth_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rec_en = 1'b0;
  logic [7:0] rec_data = 8'h00;
  logic       rec_pkt_done = 1'b0;
  logic [7:0] eth_data;
  logic       flag;
  logic       cmd_valid;
  logic [7:0] err_cnt;

  int         n_assert = 0;
  int         n_fail = 0;
  int         flag_cnt = 0;
  int         exp_flags = 0;
  logic [7:0] exp_err = 8'h00;
  logic [7:0] exp_data = 8'h00;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

`ifdef CMD_TIMEOUT_EN
  eth_cmd_decoder #(.TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst_n(rst_n), .rec_en(rec_en), .rec_data(rec_data),
    .rec_pkt_done(rec_pkt_done), .eth_data(eth_data), .flag(flag),
    .cmd_valid(cmd_valid), .err_cnt(err_cnt)
  );
`else
  eth_cmd_decoder dut (
    .clk(clk), .rst_n(rst_n), .rec_en(rec_en), .rec_data(rec_data),
    .rec_pkt_done(rec_pkt_done), .eth_data(eth_data), .flag(flag),
    .cmd_valid(cmd_valid), .err_cnt(err_cnt)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every flag pulse must match the oldest pending expected command.
  always @(negedge clk) begin
    if (rst_n && flag) begin
      flag_cnt++;
      if (sb_q.size() == 0) begin
        chk("unexpected_flag", 32'(eth_data), 32'hFFFF_FFFF);
      end else begin
        chk("flag_eth_data", 32'(eth_data), 32'(sb_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic with_done);
    rec_en       = 1'b1;
    rec_data     = b;
    rec_pkt_done = with_done;
    tick();
    rec_en       = 1'b0;
    rec_pkt_done = 1'b0;
  endtask

  task automatic done();
    rec_pkt_done = 1'b1;
    tick();
    rec_pkt_done = 1'b0;
  endtask

  task automatic expect_ok(input logic [7:0] c);
    sb_q.push_back(c);
    exp_flags++;
    exp_data = c;
  endtask

  task automatic expect_bad();
    if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
  endtask

  task automatic check_after(input string tag);
    tick();
    chk({tag, "_eth_data"}, 32'(eth_data), 32'(exp_data));
    chk({tag, "_flags"}, 32'(flag_cnt), 32'(exp_flags));
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
    chk({tag, "_flag_low"}, 32'(flag), 32'd0);
  endtask

  initial begin
    tick();
    tick();
    chk("reset_eth_data", 32'(eth_data), 32'h00);
    chk("reset_flag", 32'(flag), 32'd0);
    chk("reset_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("reset_err_cnt", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // Accept AA, with idle gaps between bytes
    send(8'h55, 1'b0); tick();
    send(8'hAA, 1'b0); tick(); tick();
    send(8'h55, 1'b0);
    expect_ok(8'hAA);
    done();
    check_after("aa");
    chk("aa_cmd_valid", 32'(cmd_valid), 32'd1);

    // Accept BB with padding
    send(8'h55, 1'b0); send(8'hBB, 1'b0); send(8'h44, 1'b0);
    send(8'h00, 1'b0); send(8'h00, 1'b0);
    expect_ok(8'hBB);
    done();
    check_after("bb_pad");

    // Bad sync, bad inverse, illegal command
    send(8'h54, 1'b0); send(8'hAA, 1'b0); send(8'h55, 1'b0); expect_bad(); done();
    check_after("bad_sync");
    send(8'h55, 1'b0); send(8'hAA, 1'b0); send(8'h54, 1'b0); expect_bad(); done();
    check_after("bad_inv");
    send(8'h55, 1'b0); send(8'h12, 1'b0); send(8'hED, 1'b0); expect_bad(); done();
    check_after("bad_cmd");
    chk("three_errs", 32'(err_cnt), 32'd3);

    // Truncated frame
    send(8'h55, 1'b0); send(8'hCC, 1'b0); expect_bad(); done();
    check_after("short");

    // Last byte and done in the same cycle commits
    send(8'h55, 1'b0); send(8'h00, 1'b0);
    expect_ok(8'h00);
    send(8'hFF, 1'b1);
    check_after("same_cycle");

    // Repeat of the same command gives two pulses
    for (int r = 0; r < 2; r++) begin
      send(8'h55, 1'b0); send(8'hCC, 1'b0);
      expect_ok(8'hCC);
      send(8'h33, 1'b0);
      done();
    end
    check_after("repeat_cc");

`ifdef CMD_TIMEOUT_EN
    expect_ok(8'h00);
    for (int i = 0; i < 150 && sb_q.size() != 0; i++) tick();
    chk("timeout_fired", 32'(sb_q.size()), 32'd0);
    check_after("timeout");
    chk("timeout_cmd_valid", 32'(cmd_valid), 32'd1);
`endif

    // Error counter saturation
    for (int i = 0; i < 256; i++) begin
      expect_bad();
      done();
    end
    check_after("sat");
    chk("sat_ff", 32'(err_cnt), 32'hFF);

    // Reset mid-frame discards the partial frame
    send(8'h55, 1'b0); send(8'hAA, 1'b0);
    rst_n = 1'b0;
    tick();
    exp_data = 8'h00;
    exp_err  = 8'h00;
    chk("rst_eth_data", 32'(eth_data), 32'h00);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    tick();
    send(8'h55, 1'b0); send(8'hBB, 1'b0); send(8'h44, 1'b0);
    expect_ok(8'hBB);
    done();
    check_after("post_rst");
    chk("post_rst_cmd_valid", 32'(cmd_valid), 32'd1);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
